// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x-oversampled 8N1 UART receiver with rdy/rdy_clr handshake
module uart_rx_os16 #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   frame_good;
    logic                   frame_bad;

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (clken) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_n = S_START;
                        cnt_n   = '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt_n     = '0;
                        bit_cnt_n = '0;
                        state_n   = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        shift_n   = {rx_s, shift[DATA_BITS-1:1]};
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = S_STOP;
                            cnt_n   = '0;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        state_n    = S_IDLE;
                        cnt_n      = '0;
                        frame_good = rx_s;
                        frame_bad  = !rx_s;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // A completing good frame overrides a same-edge rdy_clr.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            data      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
            if (frame_good) begin
                data      <= shift;
                rdy       <= 1'b1;
                frame_err <= 1'b0;
                if (rdy && !rdy_clr) begin
                    overrun <= 1'b1;
                end
            end
            if (frame_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - directed self-checking bench for uart_rx_os16
module tb_uart_rx_os16;

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b1;
    logic       clken   = 1'b1;
    logic       rx      = 1'b1;
    logic       rdy_clr = 1'b0;
    logic       rdy;
    logic [7:0] data;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int clk_div = 1;
    int div_cnt = 0;

    uart_rx_os16 dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .clken     (clken),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .rdy       (rdy),
        .data      (data),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk_50m = ~clk_50m;

    initial begin
        forever begin
            @(posedge clk_50m);
            #1;
            if (clk_div <= 1) begin
                clken = 1'b1;
            end else begin
                div_cnt = (div_cnt + 1) % clk_div;
                clken   = (div_cnt == 0);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bc);
        rx = 1'b0;
        cyc(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(bc);
        end
        rx = stop_bit;
        cyc(bc);
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        cyc(1);
        rdy_clr = 1'b0;
    endtask

    task automatic wait_rdy(input int max_cyc);
        int n;
        n = 0;
        while (!rdy && n < max_cyc) begin
            cyc(1);
            n++;
        end
    endtask

    initial begin
        int  lat;
        bit  seen;

        cyc(3);
        rst = 1'b0;
        check("reset_rdy", rdy, 0);
        check("reset_data", data, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        check("reset_busy", busy, 0);
        cyc(10);

        // 0xA5: rdy after 155 edges (2 sync + 1 detect + 152 ticks)
        fork
            send_frame(8'hA5, 1'b1, 16);
            begin
                lat = 0;
                while (!rdy && lat < 400) begin
                    cyc(1);
                    lat++;
                end
                check("a5_latency", lat, 155);
                check("a5_busy", busy, 0);
            end
        join
        check("a5_rdy", rdy, 1);
        check("a5_data", data, 8'hA5);
        check("a5_ferr", frame_err, 0);
        pulse_clr();
        check("a5_clr_rdy", rdy, 0);
        cyc(20);

        // Short glitch
        rx = 1'b0;
        cyc(4);
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (busy) seen = 1'b1;
        end
        check("glitch_busy_seen", seen, 1);
        check("glitch_busy_end", busy, 0);
        check("glitch_rdy", rdy, 0);
        check("glitch_data", data, 8'hA5);
        check("glitch_ferr", frame_err, 0);

        // Bad stop bit, then good frame
        send_frame(8'h3C, 1'b0, 16);
        cyc(40);
        check("bad_ferr", frame_err, 1);
        check("bad_rdy", rdy, 0);
        check("bad_data", data, 8'hA5);
        check("bad_busy", busy, 0);
        send_frame(8'h81, 1'b1, 16);
        check("good81_ferr", frame_err, 0);
        check("good81_rdy", rdy, 1);
        check("good81_data", data, 8'h81);
        pulse_clr();
        cyc(20);

        // Overrun
        send_frame(8'h11, 1'b1, 16);
        send_frame(8'h22, 1'b1, 16);
        check("ovr_data", data, 8'h22);
        check("ovr_rdy", rdy, 1);
        check("ovr_flag", overrun, 1);
        pulse_clr();
        check("ovr_clr_rdy", rdy, 0);
        check("ovr_clr_flag", overrun, 0);
        cyc(20);

        // rdy_clr on the completion edge: set wins, no overrun
        send_frame(8'h11, 1'b1, 16);
        check("pre_sim_rdy", rdy, 1);
        fork
            send_frame(8'h22, 1'b1, 16);
            begin
                cyc(154);
                rdy_clr = 1'b1;
                cyc(1);
                rdy_clr = 1'b0;
            end
        join
        check("sim_rdy", rdy, 1);
        check("sim_ovr", overrun, 0);
        check("sim_data", data, 8'h22);
        cyc(20);

        // Reset during data bit 4 of 0xF0 (bits 4..7 and stop are high)
        fork
            send_frame(8'hF0, 1'b1, 16);
            begin
                cyc(87);
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
                check("midrst_rdy", rdy, 0);
                check("midrst_data", data, 0);
                check("midrst_ferr", frame_err, 0);
                check("midrst_ovr", overrun, 0);
                check("midrst_busy", busy, 0);
                seen = 1'b0;
                for (int i = 0; i < 250; i++) begin
                    cyc(1);
                    if (rdy) seen = 1'b1;
                end
                check("midrst_no_rdy", seen, 0);
            end
        join
        send_frame(8'h5A, 1'b1, 16);
        check("5a_rdy", rdy, 1);
        check("5a_data", data, 8'h5A);
        check("5a_ferr", frame_err, 0);
        pulse_clr();
        cyc(20);

        // Real baud tick: one clken every 27 clocks, 432 clocks per bit
        clk_div = 27;
        cyc(60);
        fork
            begin
                send_frame(8'h00, 1'b1, 432);
                send_frame(8'hFF, 1'b1, 432);
            end
            begin
                wait_rdy(6000);
                check("b2b0_rdy", rdy, 1);
                check("b2b0_data", data, 8'h00);
                check("b2b0_ferr", frame_err, 0);
                pulse_clr();
                wait_rdy(6000);
                check("b2b1_rdy", rdy, 1);
                check("b2b1_data", data, 8'hFF);
                check("b2b1_ferr", frame_err, 0);
                check("b2b1_ovr", overrun, 0);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
